// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer that owns the HI/LO registers of the
//   pipelined MIPS core. It sits in EX beside the ALU. On start it captures the
//   result of MULTU/MULT/DIVU/DIV. It then holds busy for a fixed number of cycles
//   and commits the result to HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous reset, active low
//   start  in   1   launch op on this edge
//   op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in  32   rs operand (multiplicand / dividend)
//   b      in  32   rt operand (multiplier / divisor)
//   mthi   in   1   write wdata to HI
//   mtlo   in   1   write wdata to LO
//   wdata  in  32   MTHI/MTLO data
//   flush  in   1   abort in-flight op
//   busy   out  1   op in flight (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter is loaded with N-1 so that busy stays high for exactly N cycles:
  // (N-1) decrement cycles plus one commit cycle at zero.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic [31:0]      res_hi_reg, res_hi_next;
  logic [31:0]      res_lo_reg, res_lo_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;

  // ---------------------------------------------------------------------------
  // Result datapath (evaluated from the live operands, captured on start)
  // ---------------------------------------------------------------------------
  logic [63:0] umul, smul;
  logic [31:0] uq, ur, sq, sr;
  logic        div_zero, div_ovf;
  logic [31:0] calc_hi, calc_lo;

  assign umul = {32'b0, a} * {32'b0, b};
  assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // The quotient and remainder of a zero divisor are never selected. The muxes
  // below override them.
  assign uq = a / b;
  assign ur = a % b;
  assign sq = $unsigned($signed(a) / $signed(b));
  assign sr = $unsigned($signed(a) % $signed(b));

  assign div_zero = (b == 32'h0);
  // -2^31 / -1 has no 32-bit signed quotient. The result wraps to -2^31 with a
  // zero remainder.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    calc_hi = 32'h0;
    calc_lo = 32'h0;
    case (op)
      2'b00: {calc_hi, calc_lo} = umul;
      2'b01: {calc_hi, calc_lo} = smul;
      2'b10: begin
        if (div_zero) begin
          calc_hi = a;
          calc_lo = 32'hFFFF_FFFF;
        end else begin
          calc_hi = ur;
          calc_lo = uq;
        end
      end
      default: begin
        if (div_zero) begin
          calc_hi = a;
          calc_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          calc_hi = 32'h0;
          calc_lo = 32'h8000_0000;
        end else begin
          calc_hi = sr;
          calc_lo = sq;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // Priority in IDLE: flush > start > mthi/mtlo. In RUN: flush > commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    res_hi_next = res_hi_reg;
    res_lo_next = res_lo_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    case (state_reg)
      IDLE: begin
        if (flush) begin
          // Flush suppresses any launch or move requested on this edge.
        end else if (start) begin
          res_hi_next = calc_hi;
          res_lo_next = calc_lo;
          cnt_next    = op[1] ? DIV_LOAD : MUL_LOAD;
          state_next  = RUN;
          busy_next   = 1'b1;
        end else begin
          if (mthi) hi_next = wdata;
          if (mtlo) lo_next = wdata;
        end
      end

      RUN: begin
        // start, mthi and mtlo are ignored while an op is in flight.
        if (flush) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else if (cnt_reg == '0) begin
          hi_next    = res_hi_reg;
          lo_next    = res_lo_reg;
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      res_hi_reg <= 32'h0;
      res_lo_reg <= 32'h0;
      hi_reg     <= 32'h0;
      lo_reg     <= 32'h0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      res_hi_reg <= res_hi_next;
      res_lo_reg <= res_lo_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: table-driven vectors, hand-written multi-cycle
// sequences, and randomized ops checked against a behavioural arithmetic model.
module tb_muldiv_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  // Architectural HI/LO as the bench expects them to be.
  logic [31:0] hi_m, lo_m;

  muldiv_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .mthi (mthi),
    .mtlo (mtlo),
    .wdata(wdata),
    .flush(flush),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference for the arithmetic, computed in 64-bit integers.
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] mh, output logic [31:0] ml);
    logic [63:0] p;
    int          ia, ib;
    longint      qa, qb, q, r;
    ia = ma;
    ib = mb;
    mh = 32'h0;
    ml = 32'h0;
    if (mop == 2'd0) begin
      p  = 64'(ma) * 64'(mb);
      mh = p[63:32];
      ml = p[31:0];
    end else if (mop == 2'd1) begin
      p  = longint'(ia) * longint'(ib);
      mh = p[63:32];
      ml = p[31:0];
    end else if (mb == 32'h0) begin
      mh = ma;
      ml = 32'hFFFF_FFFF;
    end else if (mop == 2'd2) begin
      mh = ma % mb;
      ml = ma / mb;
    end else begin
      qa = longint'(ia);
      qb = longint'(ib);
      q  = qa / qb;
      r  = qa % qb;
      mh = r[31:0];
      ml = q[31:0];
    end
  endfunction

  // Launch one op and follow it through busy and commit.
  task automatic run_op(input logic [1:0] o, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit with_mtlo, input string name);
    int n;
    n     = o[1] ? DIV_N : MUL_N;
    start = 1'b1;
    op    = o;
    a     = oa;
    b     = ob;
    mtlo  = with_mtlo;
    wdata = 32'hABCD_0000;
    step();
    start = 1'b0;
    mtlo  = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({name, " busy"}, {31'b0, busy}, 32'd1);
      if (i == n - 1) begin
        chk({name, " hi held"}, hi, hi_m);
        chk({name, " lo held"}, lo, lo_m);
      end
      step();
    end
    chk({name, " busy done"}, {31'b0, busy}, 32'd0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (%s)", o, oa, ob, hi, lo, name);
    hi_m = eh;
    lo_m = el;
  endtask

  // DIVU 100/7 aborted by a flush asserted during busy cycle 'at'.
  task automatic flush_test(input int at, input string name);
    start = 1'b1;
    op    = 2'd2;
    a     = 32'd100;
    b     = 32'd7;
    step();
    start = 1'b0;
    for (int i = 1; i < at; i++) step();
    chk({name, " busy before flush"}, {31'b0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk({name, " busy"}, {31'b0, busy}, 32'd0);
    chk({name, " hi"}, hi, hi_m);
    chk({name, " lo"}, lo, lo_m);
    for (int i = 0; i < 12; i++) step();
    chk({name, " late hi"}, hi, hi_m);
    chk({name, " late lo"}, lo, lo_m);
    chk({name, " late busy"}, {31'b0, busy}, 32'd0);
    $display("flush at busy cycle %0d -> hi=%h lo=%h busy=%b", at, hi, lo, busy);
  endtask

  logic [31:0] rh, rl, ra, rb;
  logic [1:0]  ro;

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd2, 32'd9,         32'd0,        32'h0000_0009, 32'hFFFF_FFFF};
    vecs[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0; flush = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    @(negedge clk);
    step();
    step();
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    rst_n = 1'b1;
    step();

    // Table-driven arithmetic vectors.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0,
             $sformatf("vec%0d", i));

    // MTHI / MTLO in IDLE.
    mthi = 1'b1; wdata = 32'h1234;
    step();
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    hi_m = 32'h1234;
    mtlo = 1'b1; wdata = 32'h5678;
    step();
    mtlo = 1'b0;
    chk("mtlo lo", lo, 32'h5678);
    chk("mtlo hi", hi, 32'h1234);
    chk("mtlo busy", {31'b0, busy}, 32'd0);
    lo_m = 32'h5678;
    $display("mthi/mtlo -> hi=%h lo=%h busy=%b", hi, lo, busy);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo hi", hi, 32'hCAFE_F00D);
    chk("mthilo lo", lo, 32'hCAFE_F00D);
    hi_m = 32'hCAFE_F00D; lo_m = 32'hCAFE_F00D;
    $display("mthi+mtlo -> hi=%h lo=%h", hi, lo);

    // Flush in IDLE beats start and moves.
    flush = 1'b1; start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    mthi = 1'b1; wdata = 32'h1111;
    step();
    flush = 1'b0; start = 1'b0; mthi = 1'b0;
    chk("idle flush busy", {31'b0, busy}, 32'd0);
    chk("idle flush hi", hi, hi_m);
    step();
    chk("idle flush busy2", {31'b0, busy}, 32'd0);
    chk("idle flush lo", lo, lo_m);
    $display("idle flush+start+mthi -> busy=%b hi=%h", busy, hi);

    // Moves during RUN are ignored; MULT 6*7 commits normally.
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    step();
    start = 1'b0;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("run move hi", hi, hi_m);
    chk("run move lo", lo, lo_m);
    chk("run move busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < MUL_N - 1; i++) step();
    chk("run move done busy", {31'b0, busy}, 32'd0);
    chk("run move commit hi", hi, 32'h0);
    chk("run move commit lo", lo, 32'd42);
    hi_m = 32'h0; lo_m = 32'd42;
    $display("moves during MULT -> hi=%h lo=%h", hi, lo);

    // Flush during RUN, mid-op and on the final busy cycle.
    flush_test(4, "flush4");
    flush_test(DIV_N, "flushlast");

    // Randomized ops against the model, with occasional moves.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, rh, rl);
      run_op(ro, ra, rb, rh, rl, 1'b0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        mthi = 1'($urandom_range(0, 1));
        mtlo = ~mthi;
        wdata = $urandom;
        step();
        if (mthi) hi_m = wdata; else lo_m = wdata;
        mthi = 1'b0; mtlo = 1'b0;
        chk($sformatf("rnd%0d move hi", i), hi, hi_m);
        chk($sformatf("rnd%0d move lo", i), lo, lo_m);
      end
    end

    // Reset mid-MULT.
    start = 1'b1; op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    hi_m = 32'h0; lo_m = 32'h0;
    for (int i = 0; i < 8; i++) step();
    chk("midrst late busy", {31'b0, busy}, 32'd0);
    chk("midrst late lo", lo, 32'h0);
    $display("reset mid-MULT -> busy=%b hi=%h lo=%h", busy, hi, lo);

    // start together with mtlo: the move is dropped and the op commits.
    run_op(2'd0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b1, "start+mtlo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
